// File: rtl/gpi_cond_pkg.sv
// Shared constants and types for the GPIO input conditioner.
// Debounce hardware is only built when GPI_COND_DEBOUNCE_EN is defined.
package gpi_cond_pkg;

  localparam int GPI_WIDTH           = 8;
  localparam int GPI_SYNC_STAGES_DEF = 2;
  localparam int GPI_DB_CYCLES_DEF   = 16;

  typedef logic [GPI_WIDTH-1:0] gpi_vec_t;

  // Counter must be able to hold DB_CYCLES-1 for any legal DB_CYCLES.
  function automatic int db_cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/gpi_cond_bit.sv
// One conditioned pin: synchroniser, optional stability counter, level and edge pulses.
// Debounce counter is built only when GPI_COND_DEBOUNCE_EN is defined.
module gpi_cond_bit
  import gpi_cond_pkg::*;
#(
  parameter int SYNC_STAGES = GPI_SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = GPI_DB_CYCLES_DEF
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 1) begin : g_param_check
    $error("gpi_cond_bit: SYNC_STAGES must be 2..4 and DB_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_level;
  logic                   r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPI_COND_DEBOUNCE_EN
  localparam int                CNT_W    = db_cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter only runs while the synchronised pin disagrees with the accepted level.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= w_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_level <= 1'b0;
    else        r_level <= w_sync;
  end
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_prev <= 1'b0;
    else        r_prev <= r_level;
  end

  // Both terms are zero in reset, so reset itself can never emit a pulse.
  assign o_level = r_level;
  assign o_rise  = r_level & ~r_prev;
  assign o_fall  = ~r_level & r_prev;

endmodule

// File: rtl/gpi_input_conditioner.sv
// Conditions raw GPIO pads for the GPI peripheral: per-bit sync, debounce, edge pulses.
// Debounce is enabled by defining GPI_COND_DEBOUNCE_EN.
module gpi_input_conditioner
  import gpi_cond_pkg::*;
#(
  parameter int WIDTH       = GPI_WIDTH,
  parameter int SYNC_STAGES = GPI_SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = GPI_DB_CYCLES_DEF
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] pinIn,
  output logic [WIDTH-1:0] inPort,
  output logic [WIDTH-1:0] risePulse,
  output logic [WIDTH-1:0] fallPulse,
  output logic             anyEdge
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpi_cond_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_bit (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .i_pin   (pinIn[i]),
      .o_level (inPort[i]),
      .o_rise  (risePulse[i]),
      .o_fall  (fallPulse[i])
    );
  end

  assign anyEdge = |{risePulse, fallPulse};

endmodule
